// File: rtl/msrv_32_lsu.sv
// Load/store unit for the msrv_32 execute stage: effective-address generation,
// single-outstanding req/ack data-memory transaction, load alignment and store lane building.
module msrv_32_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        ms_risc32_mp_clk_in,
    input  logic        ms_risc32_mp_rst_n_in,
    input  logic        mem_rd_en_in,
    input  logic        mem_wr_en_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] rs2_in,
    input  logic [31:0] imm_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] dmem_rdata_in,
    input  logic        dmem_ack_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wr_mask_out,
    output logic        lsu_stall_out,
    output logic        lsu_done_out,
    output logic [31:0] load_data_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       mask_q, mask_d;
    logic             done_q, done_d;
    logic             mis_q, mis_d;
    logic             err_q, err_d;
    logic [31:0]      load_data_q, load_data_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;

    logic [31:0]      ea;
    logic             ea_misaligned;
    logic [31:0]      st_wdata;
    logic [3:0]       st_mask;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_fmt;

    assign ea = rs1_in + imm_in;

    always_comb begin
        ea_misaligned = 1'b0;
        st_wdata      = rs2_in;
        st_mask       = 4'b1111;
        case (load_size_in)
            2'b00: begin
                st_wdata = {4{rs2_in[7:0]}};
                st_mask  = 4'b0001 << ea[1:0];
            end
            2'b01: begin
                ea_misaligned = ea[0];
                st_wdata      = {2{rs2_in[15:0]}};
                st_mask       = 4'b0011 << ea[1:0];
            end
            default: begin
                ea_misaligned = (ea[1:0] != 2'b00);
            end
        endcase
    end

    // Load formatting works from the latched offset/size so operands may change during REQ
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata_in[7:0];
            2'd1:    ld_byte = dmem_rdata_in[15:8];
            2'd2:    ld_byte = dmem_rdata_in[23:16];
            default: ld_byte = dmem_rdata_in[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (size_q)
            2'b00:   ld_fmt = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_fmt = dmem_rdata_in;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        err_d       = 1'b0;
        load_data_d = load_data_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (mem_rd_en_in || mem_wr_en_in) begin
                    we_d    = mem_wr_en_in;
                    size_d  = load_size_in;
                    uns_d   = load_unsigned_in;
                    off_d   = ea[1:0];
                    addr_d  = {ea[31:2], 2'b00};
                    wdata_d = st_wdata;
                    mask_d  = st_mask;
                    if (ea_misaligned) begin
                        state_d     = ST_RESP;
                        done_d      = 1'b1;
                        mis_d       = 1'b1;
                        load_data_d = '0;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end
                end
            end

            // Ack wins over a timeout expiring in the same cycle
            ST_REQ: begin
                if (dmem_ack_in) begin
                    state_d     = ST_RESP;
                    req_d       = 1'b0;
                    done_d      = 1'b1;
                    load_data_d = we_q ? 32'd0 : ld_fmt;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    req_d       = 1'b0;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_n_in) begin
        if (!ms_risc32_mp_rst_n_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
        end
    end

    // Stall is forced low while reset is held so every output reads zero
    assign lsu_stall_out = ms_risc32_mp_rst_n_in &
                           (((state_q == ST_IDLE) & (mem_rd_en_in | mem_wr_en_in)) |
                            (state_q == ST_REQ));

    assign dmem_req_out     = req_q;
    assign dmem_we_out      = we_q;
    assign dmem_addr_out    = addr_q;
    assign dmem_wdata_out   = wdata_q;
    assign dmem_wr_mask_out = mask_q;
    assign lsu_done_out     = done_q;
    assign misaligned_out   = mis_q;
    assign bus_err_out      = err_q;
    assign load_data_out    = load_data_q;

endmodule

// File: tb/tb_msrv_32_lsu.sv
// Self-checking bench for msrv_32_lsu: directed vector table, randomized ops against
// an arithmetic reference model, plus timeout and mid-transaction reset sequences.
module tb_msrv_32_lsu;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [31:0] imm = '0;
    logic [1:0]  size = '0;
    logic        uns = 1'b0;
    logic [31:0] rdata = '0;
    logic        ack = 1'b0;
    logic        req, we, stall, done, mis, err;
    logic [31:0] addr, wdata, load_data;
    logic [3:0]  mask;

    int total = 0;
    int bad = 0;
    logic [31:0] prev_load = '0;

    always #5 clk = ~clk;

    msrv_32_lsu #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .ms_risc32_mp_clk_in   (clk),
        .ms_risc32_mp_rst_n_in (rst_n),
        .mem_rd_en_in          (rd_en),
        .mem_wr_en_in          (wr_en),
        .rs1_in                (rs1),
        .rs2_in                (rs2),
        .imm_in                (imm),
        .load_size_in          (size),
        .load_unsigned_in      (uns),
        .dmem_rdata_in         (rdata),
        .dmem_ack_in           (ack),
        .dmem_req_out          (req),
        .dmem_we_out           (we),
        .dmem_addr_out         (addr),
        .dmem_wdata_out        (wdata),
        .dmem_wr_mask_out      (mask),
        .lsu_stall_out         (stall),
        .lsu_done_out          (done),
        .load_data_out         (load_data),
        .misaligned_out        (mis),
        .bus_err_out           (err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        int          ack_k;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
        logic [3:0]  e_mask;
        logic        e_mis;
        logic        e_err;
    } vec_t;

    task automatic checkOutput(input string tag, input string what,
                               input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s/%s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] i,
                                input logic [1:0] s, input logic u, input logic [31:0] rdv,
                                input int k, input logic [31:0] ea, input logic [31:0] ewd,
                                input logic [31:0] eld, input logic [3:0] em,
                                input logic emis, input logic eerr);
        vec_t v;
        v.rd = r; v.wr = w; v.rs1 = a; v.rs2 = d; v.imm = i; v.size = s; v.uns = u;
        v.rdata = rdv; v.ack_k = k; v.e_addr = ea; v.e_wdata = ewd; v.e_load = eld;
        v.e_mask = em; v.e_mis = emis; v.e_err = eerr;
        return v;
    endfunction

    // Reference model: byte-level arithmetic on the effective address and access width
    function automatic vec_t model(input vec_t v);
        vec_t r;
        longint unsigned ea, val, span;
        int off, nb;
        r = v;
        ea = ({32'd0, v.rs1} + {32'd0, v.imm}) % 64'h1_0000_0000;
        off = int'(ea % 4);
        nb = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        r.e_mis = (ea % longint'(nb)) != 0;
        r.e_err = !r.e_mis && (v.ack_k == 0);
        r.e_addr = 32'(ea - longint'(off));
        r.e_mask = 4'(((1 << nb) - 1) << off);
        if (nb == 1)      r.e_wdata = (v.rs2 % 256) * 32'h0101_0101;
        else if (nb == 2) r.e_wdata = (v.rs2 % 65536) * 32'h0001_0001;
        else              r.e_wdata = v.rs2;
        if (v.wr || r.e_mis || r.e_err) begin
            r.e_load = '0;
        end else begin
            span = 64'd1 << (8 * nb);
            val = ({32'd0, v.rdata} >> (8 * off)) % span;
            if (!v.uns && nb < 4 && val >= span / 2) val = val + 64'h1_0000_0000 - span;
            r.e_load = 32'(val);
        end
        return r;
    endfunction

    // Runs one operation from its IDLE accept cycle through RESP and checks the timing
    task automatic applyStimulus(input vec_t v, input string tag);
        int cyc, stall_n, req_n, done_cyc, e_req, e_stall, e_done;
        logic [31:0] got_load;
        logic got_mis, got_err;
        got_load = '0; got_mis = 1'b0; got_err = 1'b0;
        @(negedge clk);
        checkOutput(tag, "done_idle", {31'd0, done}, 32'd0);
        checkOutput(tag, "load_hold", load_data, prev_load);
        rd_en = v.rd; wr_en = v.wr; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
        size = v.size; uns = v.uns; ack = 1'($urandom); rdata = $urandom;
        #1;
        stall_n = stall ? 1 : 0;
        req_n = 0;
        done_cyc = 0;
        cyc = 1;
        while (done_cyc == 0 && cyc < TIMEOUT + 10) begin
            @(negedge clk);
            cyc++;
            if (stall) stall_n++;
            ack = 1'b0;
            rdata = $urandom;
            if (req) begin
                req_n++;
                checkOutput(tag, "addr", addr, v.e_addr);
                checkOutput(tag, "we", {31'd0, we}, {31'd0, v.wr});
                checkOutput(tag, "mask", {28'd0, mask}, {28'd0, v.e_mask});
                if (v.wr) checkOutput(tag, "wdata", wdata, v.e_wdata);
                if (req_n == v.ack_k) begin
                    ack = 1'b1;
                    rdata = v.rdata;
                end
            end
            if (done) begin
                done_cyc = cyc;
                got_load = load_data;
                got_mis = mis;
                got_err = err;
            end
            rs1 = $urandom; rs2 = $urandom; imm = $urandom;
            size = 2'($urandom); uns = 1'($urandom);
        end
        rd_en = 1'b0; wr_en = 1'b0; ack = 1'b0;
        if (v.e_mis) begin
            e_req = 0; e_stall = 1; e_done = 2;
        end else if (v.ack_k == 0) begin
            e_req = TIMEOUT; e_stall = TIMEOUT + 1; e_done = TIMEOUT + 2;
        end else begin
            e_req = v.ack_k; e_stall = v.ack_k + 1; e_done = v.ack_k + 2;
        end
        checkOutput(tag, "req_cycles", 32'(req_n), 32'(e_req));
        checkOutput(tag, "stall_cycles", 32'(stall_n), 32'(e_stall));
        checkOutput(tag, "done_cycle", 32'(done_cyc), 32'(e_done));
        checkOutput(tag, "misaligned", {31'd0, got_mis}, {31'd0, v.e_mis});
        checkOutput(tag, "bus_err", {31'd0, got_err}, {31'd0, v.e_err});
        checkOutput(tag, "load_data", got_load, v.e_load);
        prev_load = v.e_load;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, "req", {31'd0, req}, 32'd0);
        checkOutput(tag, "stall", {31'd0, stall}, 32'd0);
        checkOutput(tag, "done", {31'd0, done}, 32'd0);
        checkOutput(tag, "we", {31'd0, we}, 32'd0);
        checkOutput(tag, "addr", addr, 32'd0);
        checkOutput(tag, "wdata", wdata, 32'd0);
        checkOutput(tag, "mask", {28'd0, mask}, 32'd0);
        checkOutput(tag, "load_data", load_data, 32'd0);
        checkOutput(tag, "misaligned", {31'd0, mis}, 32'd0);
        checkOutput(tag, "bus_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        vec_t tbl[16];
        vec_t v;
        int r;

        tbl[0]  = mk(1, 0, 32'h1000, 32'h0, 32'h4, 2'd2, 0, 32'hDEADBEEF, 1,
                     32'h1004, 32'h0, 32'hDEADBEEF, 4'hF, 0, 0);
        tbl[1]  = mk(1, 0, 32'h2000, 32'h0, 32'h3, 2'd0, 0, 32'h80123456, 2,
                     32'h2000, 32'h0, 32'hFFFFFF80, 4'h8, 0, 0);
        tbl[2]  = mk(1, 0, 32'h2000, 32'h0, 32'h3, 2'd0, 1, 32'h80123456, 1,
                     32'h2000, 32'h0, 32'h00000080, 4'h8, 0, 0);
        tbl[3]  = mk(1, 0, 32'h2000, 32'h0, 32'h2, 2'd1, 1, 32'h80123456, 1,
                     32'h2000, 32'h0, 32'h00008012, 4'hC, 0, 0);
        tbl[4]  = mk(0, 1, 32'h0100, 32'h1234ABCD, 32'h2, 2'd1, 0, 32'hFFFFFFFF, 3,
                     32'h0100, 32'hABCDABCD, 32'h0, 4'hC, 0, 0);
        tbl[5]  = mk(1, 0, 32'h1000, 32'h0, 32'h1, 2'd2, 0, 32'h12345678, 1,
                     32'h0, 32'h0, 32'h0, 4'h0, 1, 0);
        tbl[6]  = mk(1, 0, 32'h3000, 32'h0, 32'hFFFFFFFE, 2'd1, 0, 32'h80017FFF, 2,
                     32'h2FFC, 32'h0, 32'hFFFF8001, 4'hC, 0, 0);
        tbl[7]  = mk(0, 1, 32'h10, 32'h000000A5, 32'h1, 2'd0, 0, 32'h0, 1,
                     32'h10, 32'hA5A5A5A5, 32'h0, 4'h2, 0, 0);
        tbl[8]  = mk(1, 1, 32'h40, 32'hCAFEF00D, 32'h0, 2'd3, 0, 32'h77777777, 2,
                     32'h40, 32'hCAFEF00D, 32'h0, 4'hF, 0, 0);
        tbl[9]  = mk(1, 0, 32'h5, 32'h0, 32'h0, 2'd1, 0, 32'h0, 1,
                     32'h0, 32'h0, 32'h0, 4'h0, 1, 0);
        tbl[10] = mk(0, 1, 32'h7, 32'h12, 32'h0, 2'd0, 0, 32'h0, 1,
                     32'h4, 32'h12121212, 32'h0, 4'h8, 0, 0);
        tbl[11] = mk(1, 0, 32'hFFFFFFFC, 32'h0, 32'h8, 2'd2, 0, 32'h11223344, 1,
                     32'h4, 32'h0, 32'h11223344, 4'hF, 0, 0);
        tbl[12] = mk(1, 0, 32'h3000, 32'h0, 32'h0, 2'd2, 0, 32'h0, 0,
                     32'h3000, 32'h0, 32'h0, 4'hF, 0, 1);
        tbl[13] = mk(1, 0, 32'h3000, 32'h0, 32'h0, 2'd3, 0, 32'h55AA55AA, 1,
                     32'h3000, 32'h0, 32'h55AA55AA, 4'hF, 0, 0);
        tbl[14] = mk(1, 0, 32'h2000, 32'h0, 32'h0, 2'd1, 0, 32'h80127FFF, 4,
                     32'h2000, 32'h0, 32'h00007FFF, 4'h3, 0, 0);
        tbl[15] = mk(0, 1, 32'h0, 32'hFFFF, 32'h2, 2'd2, 0, 32'h0, 1,
                     32'h0, 32'h0, 32'h0, 4'h0, 1, 0);

        #1 rst_n = 1'b0;
        rd_en = 1'b1;
        #2;
        checkAllZero("reset");
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 2));
            v.rd = (r != 1);
            v.wr = (r != 0);
            v.rs1 = $urandom;
            v.rs2 = $urandom;
            v.imm = 32'($urandom_range(0, 255)) - 32'd128;
            v.size = 2'($urandom);
            v.uns = 1'($urandom);
            v.rdata = $urandom;
            v.ack_k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            v = model(v);
            applyStimulus(v, $sformatf("rand%0d", i));
        end

        applyStimulus(tbl[0], "pre_reset");
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b0; rs1 = 32'h1000; imm = 32'h0; size = 2'd2; ack = 1'b0;
        @(negedge clk);
        checkOutput("midreset", "req_1st", {31'd0, req}, 32'd1);
        @(negedge clk);
        checkOutput("midreset", "req_2nd", {31'd0, req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        prev_load = '0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ack = 1'b1;
        rdata = 32'hBAADF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("late_ack", "req", {31'd0, req}, 32'd0);
            checkOutput("late_ack", "done", {31'd0, done}, 32'd0);
            checkOutput("late_ack", "load_data", load_data, 32'd0);
        end
        ack = 1'b0;
        applyStimulus(tbl[0], "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
